// File: rtl/interrupt_ctrl.sv
// Interrupt controller: edge-detects pulse lines into pending bits, masks and prioritises them,
// and holds one level request with source ID until the CPU acks. Registered rdata, 1-cycle read latency.
module interrupt_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [1:0]         addr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    output logic               irq_out,
    output logic [2:0]         irq_id,
    input  logic               ack
);

    typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

    state_t             state_q;
    logic               irq_out_q;
    logic [2:0]         irq_id_q;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]   ovr_q, ovr_d;
    logic [7:0]         rdata_q, rdata_d;

    logic [NUM_SRC-1:0] edge_v, id_sel, clr, req, wbits;
    logic               wr_pend, wr_mask, wr_ovr, drop;
    logic [2:0]         first_id;
    logic               unused_wdata;

    function automatic logic [2:0] lowest(input logic [NUM_SRC-1:0] v);
        lowest = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) lowest = 3'(i);
        end
    endfunction

    assign unused_wdata = ^wdata;

    always_comb begin
        wbits    = wdata[NUM_SRC-1:0];
        edge_v   = irq_in & ~prev_q;
        id_sel   = NUM_SRC'(1) << irq_id_q;
        wr_pend  = wr_en && (addr == 2'd0);
        wr_mask  = wr_en && (addr == 2'd1);
        wr_ovr   = wr_en && (addr == 2'd3);
        clr      = ((state_q == ASSERT) && ack) ? id_sel : '0;
        if (wr_pend) clr = clr | wbits;
        // Set wins over clear: an edge landing on its own clear keeps the bit pending.
        pend_d   = (pend_q & ~clr) | edge_v;
        mask_d   = wr_mask ? wbits : mask_q;
        req      = pend_q & mask_q;
        first_id = lowest(req);
        drop     = ack || (wr_pend && |(wbits & id_sel)) || (wr_mask && !(|(wbits & id_sel)));

        ovr_d = ovr_q;
        if (wr_ovr) begin
            ovr_d = '0;
        end else if (|(edge_v & pend_q & ~clr) && (ovr_q != {CNT_W{1'b1}})) begin
            ovr_d = ovr_q + 1'b1;
        end

        rdata_d = rdata_q;
        if (rd_en) begin
            case (addr)
                2'd0:    rdata_d = 8'(pend_q);
                2'd1:    rdata_d = 8'(mask_q);
                2'd2:    rdata_d = {irq_out_q, 4'b0000, irq_id_q};
                default: rdata_d = 8'(ovr_q);
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            ovr_q   <= '0;
            rdata_q <= '0;
        end else begin
            prev_q  <= irq_in;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            ovr_q   <= ovr_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            irq_out_q <= 1'b0;
            irq_id_q  <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        irq_id_q  <= first_id;
                        irq_out_q <= 1'b1;
                        state_q   <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (drop) begin
                        irq_out_q <= 1'b0;
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    irq_out_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign rdata   = rdata_q;
    assign irq_out = irq_out_q;
    assign irq_id  = irq_id_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Bench for interrupt_ctrl: two instances (8-bit and 2-bit overrun counters) share stimulus;
// expectations from a reference model are queued and popped by an independent monitor.
module tb_interrupt_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] irq_in = '0;
    logic       wr_en = 1'b0, rd_en = 1'b0, ack = 1'b0;
    logic [1:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata, rdata2;
    logic       irq_out, irq_out2;
    logic [2:0] irq_id, irq_id2;

    always #5 clk = ~clk;

    interrupt_ctrl #(.NUM_SRC(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .irq_out(irq_out), .irq_id(irq_id), .ack(ack)
    );

    interrupt_ctrl #(.NUM_SRC(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .irq_in(irq_in), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .wdata(wdata), .rdata(rdata2), .irq_out(irq_out2), .irq_id(irq_id2), .ack(ack)
    );

    int total = 0;
    int bad = 0;

    typedef struct { logic [7:0] r8; logic [7:0] r2; } rd_exp_t;
    typedef struct { logic irq; logic [2:0] id; } irq_exp_t;
    rd_exp_t  rd_q[$];
    irq_exp_t irq_q[$];

    // Reference model state: sets as bit vectors, counters as plain integers.
    logic [3:0] m_prev, m_pend, m_mask;
    int         m_ovr8, m_ovr2, m_id;
    bit         m_irq, m_cool;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_pend = '0; m_mask = '0;
        m_ovr8 = 0; m_ovr2 = 0; m_id = 0;
        m_irq = 1'b0; m_cool = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] e, clr, req;
        rd_exp_t    r;
        irq_exp_t   x;
        if (rd_en) begin
            case (addr)
                2'd0:    r.r8 = {4'b0, m_pend};
                2'd1:    r.r8 = {4'b0, m_mask};
                2'd2:    r.r8 = {m_irq, 4'b0, 3'(m_id)};
                default: r.r8 = 8'(m_ovr8);
            endcase
            r.r2 = (addr == 2'd3) ? 8'(m_ovr2) : r.r8;
            rd_q.push_back(r);
        end
        e   = irq_in & ~m_prev;
        clr = (m_irq && ack) ? 4'(1 << m_id) : 4'b0;
        if (wr_en && addr == 2'd0) clr = clr | wdata[3:0];
        req = m_pend & m_mask;
        if (m_irq) begin
            if (ack || (wr_en && addr == 2'd0 && wdata[m_id]) || (wr_en && addr == 2'd1 && !wdata[m_id])) begin
                m_irq  = 1'b0;
                m_cool = 1'b1;
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else if (req != 0) begin
            m_irq = 1'b1;
            for (int i = 3; i >= 0; i--) if (req[i]) m_id = i;
        end
        if (wr_en && addr == 2'd3) begin
            m_ovr8 = 0;
            m_ovr2 = 0;
        end else if ((e & m_pend & ~clr) != 0) begin
            if (m_ovr8 < 255) m_ovr8++;
            if (m_ovr2 < 3) m_ovr2++;
        end
        if (wr_en && addr == 2'd1) m_mask = wdata[3:0];
        m_pend = (m_pend & ~clr) | e;
        m_prev = irq_in;
        x.irq = m_irq;
        x.id  = 3'(m_id);
        irq_q.push_back(x);
    endtask

    // Monitor: samples 2 time units after each rising edge.
    initial begin
        irq_exp_t ie;
        rd_exp_t  re;
        forever begin
            @(posedge clk);
            #2;
            if (!reset) begin
                if (irq_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL irq_queue: no expectation queued");
                end else begin
                    ie = irq_q.pop_front();
                    check("irq_out", 8'(irq_out), 8'(ie.irq));
                    check("irq_out2", 8'(irq_out2), 8'(ie.irq));
                    if (ie.irq) begin
                        check("irq_id", 8'(irq_id), 8'(ie.id));
                        check("irq_id2", 8'(irq_id2), 8'(ie.id));
                    end
                end
                if (rd_en) begin
                    if (rd_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rd_queue: no expectation queued");
                    end else begin
                        re = rd_q.pop_front();
                        check("rdata", rdata, re.r8);
                        check("rdata2", rdata2, re.r2);
                    end
                end
            end
        end
    end

    task automatic step();
        model_step();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        step();
    endtask

    task automatic rd(input logic [1:0] a);
        rd_en = 1'b1; addr = a;
        step();
    endtask

    task automatic pulse(input logic [3:0] bits, input int len);
        irq_in = irq_in | bits;
        repeat (len) step();
        irq_in = irq_in & ~bits;
        step();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_irq_out", 8'(irq_out), 8'h00);
        check("rst_irq_id", 8'(irq_id), 8'h00);
        check("rst_rdata", rdata, 8'h00);
        reset = 1'b0;

        // Single source, priority-0 path
        wr(2'd1, 8'h01);
        irq_in = 4'b0001; step();
        step();
        check("t1_irq_out", 8'(irq_out), 8'h01);
        check("t1_irq_id", 8'(irq_id), 8'h00);
        step(); irq_in = 4'b0000;
        rd(2'd0); check("t1_pending", rdata, 8'h01);
        ack = 1'b1; step();
        check("t1_drop", 8'(irq_out), 8'h00);
        rd(2'd0); check("t1_pend_clr", rdata, 8'h00);

        // Simultaneous sources 1 and 2
        wr(2'd1, 8'h0F);
        irq_in = 4'b0110; step();
        step();
        check("t2_first_id", 8'(irq_id), 8'h01);
        step(); irq_in = 4'b0000;
        ack = 1'b1; step();
        step(); step();
        check("t2_second_irq", 8'(irq_out), 8'h01);
        check("t2_second_id", 8'(irq_id), 8'h02);
        ack = 1'b1; step();
        step();
        rd(2'd0); check("t2_pend_clr", rdata, 8'h00);

        // Masked source, then unmask
        wr(2'd1, 8'h00);
        pulse(4'b1000, 3);
        check("t3_masked", 8'(irq_out), 8'h00);
        rd(2'd0); check("t3_pending", rdata, 8'h08);
        wr(2'd1, 8'h08);
        step();
        check("t3_unmask_irq", 8'(irq_out), 8'h01);
        check("t3_unmask_id", 8'(irq_id), 8'h03);
        ack = 1'b1; step();
        repeat (2) step();

        // Overrun counting and saturation
        wr(2'd1, 8'h01);
        repeat (3) pulse(4'b0001, 3);
        rd(2'd3);
        check("t4_ovr8", rdata, 8'h02);
        check("t4_ovr2", rdata2, 8'h02);
        wr(2'd3, 8'h00);
        rd(2'd3); check("t4_ovr_clr", rdata, 8'h00);
        repeat (5) pulse(4'b0001, 3);
        rd(2'd3);
        check("t4_ovr8_five", rdata, 8'h05);
        check("t4_ovr2_sat", rdata2, 8'h03);

        // Edge coinciding with ack of the same source
        wr(2'd3, 8'h00);
        irq_in = 4'b0001; ack = 1'b1; step();
        check("t5_gap", 8'(irq_out), 8'h00);
        step(); step();
        irq_in = 4'b0000;
        check("t5_reassert", 8'(irq_out), 8'h01);
        rd(2'd0); check("t5_pending", rdata, 8'h01);
        rd(2'd3); check("t5_ovr", rdata, 8'h00);

        // Async reset while requesting
        check("t6_pre_irq", 8'(irq_out), 8'h01);
        reset = 1'b1;
        #1;
        check("t6_async_drop", 8'(irq_out), 8'h00);
        model_reset();
        irq_in = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        rd(2'd0); check("t6_pending", rdata, 8'h00);
        rd(2'd1); check("t6_mask", rdata, 8'h00);
        rd(2'd3);
        check("t6_ovr8", rdata, 8'h00);
        check("t6_ovr2", rdata2, 8'h00);

        // Randomised traffic against the model
        repeat (3000) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(3) == 0) irq_in[i] = ~irq_in[i];
            ack   = ($urandom_range(2) == 0);
            wr_en = ($urandom_range(7) == 0);
            rd_en = ($urandom_range(1) == 0);
            addr  = 2'($urandom_range(3));
            wdata = 8'($urandom);
            step();
        end
        irq_in = 4'b0000;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
